// File: rtl/i2c_write_sequencer.sv
// I2C register-write sequencer: the first byte after START loads the register pointer and later bytes are written to the register store.
// Optional macro WRITE_SEQ_PROTECT_EN drops writes to reserved registers, and to PRE_SCALE while awake, and sets error_o.
module i2c_write_sequencer #(
    parameter logic [7:0] LOW_MAX_REG  = 8'h45,
    parameter logic [7:0] HIGH_MIN_REG = 8'hFA
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    input  logic       auto_increment_i,
    input  logic       sleep_i,
    output logic [7:0] write_register_id_o,
    output logic [7:0] write_register_value_o,
    output logic       write_enable_o,
    output logic [7:0] pointer_o,
    output logic       error_o
);

    typedef enum logic [1:0] {IDLE, PTR, DATA} state_e;

    state_e     state_q, state_d;
    logic [7:0] pointer_q, pointer_d;
    logic       pend_q, pend_d;
    logic [7:0] pend_id_q, pend_id_d;
    logic [7:0] pend_val_q, pend_val_d;
    logic [7:0] id_q, id_d;
    logic [7:0] val_q, val_d;
    logic       we_q, we_d;
    logic       drop;

    function automatic logic [7:0] next_ptr(input logic [7:0] p, input logic ai);
        if (!ai)                return p;
        else if (p == LOW_MAX_REG) return 8'h00;
        else if (p == 8'hFD)       return HIGH_MIN_REG;
        else if (p == 8'hFF)       return 8'h00;
        else                       return p + 8'd1;
    endfunction

`ifdef WRITE_SEQ_PROTECT_EN
    logic err_q, err_d;

    assign drop = ((pointer_q > LOW_MAX_REG) && (pointer_q < HIGH_MIN_REG)) ||
                  ((pointer_q == 8'hFE) && !sleep_i);

    always_comb begin
        err_d = err_q;
        if (start_i)
            err_d = 1'b0;
        else if ((state_q == DATA) && byte_valid_i && drop)
            err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign error_o = err_q;
`else
    logic unused_sleep;
    assign unused_sleep = sleep_i;
    assign drop         = 1'b0;
    assign error_o      = 1'b0;
`endif

    // An accepted byte is held in a pending stage for one cycle.
    // The strobe follows on the next edge, so a reset in that cycle cancels it.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        pointer_d  = pointer_q;
        pend_d     = 1'b0;
        pend_id_d  = pend_id_q;
        pend_val_d = pend_val_q;
        we_d       = pend_q;
        id_d       = id_q;
        val_d      = val_q;

        if (pend_q) begin
            id_d  = pend_id_q;
            val_d = pend_val_q;
        end

        if (start_i) begin
            state_d = PTR;
        end else begin
            case (state_q)
                PTR: begin
                    if (byte_valid_i) begin
                        pointer_d = byte_i;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (byte_valid_i) begin
                        pend_d     = !drop;
                        pend_id_d  = pointer_q;
                        pend_val_d = byte_i;
                        pointer_d  = next_ptr(pointer_q, auto_increment_i);
                    end
                end
                default: ;
            endcase
            if (stop_i) state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pointer_q  <= 8'h00;
            pend_q     <= 1'b0;
            pend_id_q  <= 8'h00;
            pend_val_q <= 8'h00;
            id_q       <= 8'h00;
            val_q      <= 8'h00;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pointer_q  <= pointer_d;
            pend_q     <= pend_d;
            pend_id_q  <= pend_id_d;
            pend_val_q <= pend_val_d;
            id_q       <= id_d;
            val_q      <= val_d;
            we_q       <= we_d;
        end
    end

    assign write_register_id_o    = id_q;
    assign write_register_value_o = val_q;
    assign write_enable_o         = we_q;
    assign pointer_o              = pointer_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer: a table of per-cycle vectors plus a hand-written back-to-back burst.
// The expected results cover both builds, with and without WRITE_SEQ_PROTECT_EN.
module tb_i2c_write_sequencer;

`ifdef WRITE_SEQ_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, stop, bv, ai, slp;
    logic [7:0] din;
    logic [7:0] wid, wval, ptr;
    logic       we, err;

    i2c_write_sequencer dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .start_i                (start),
        .stop_i                 (stop),
        .byte_valid_i           (bv),
        .byte_i                 (din),
        .auto_increment_i       (ai),
        .sleep_i                (slp),
        .write_register_id_o    (wid),
        .write_register_value_o (wval),
        .write_enable_o         (we),
        .pointer_o              (ptr),
        .error_o                (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         rst, st, sp, bv;
        logic [7:0] b;
        bit         ai, slp;
        bit         ewe;
        logic [7:0] eid, evl, eptr;
        bit         eerr;
        bit         iv;    // id/value are compared only when this is set
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic vec_t v(string nm, bit r, bit s, bit p, bit b_v, logic [7:0] b,
                               bit a, bit sl, bit ewe, logic [7:0] eid, logic [7:0] evl,
                               logic [7:0] eptr, bit eerr, bit iv);
        vec_t x;
        x.name = nm; x.rst = r; x.st = s; x.sp = p; x.bv = b_v; x.b = b; x.ai = a; x.slp = sl;
        x.ewe = ewe; x.eid = eid; x.evl = evl; x.eptr = eptr; x.eerr = eerr; x.iv = iv;
        return x;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(bit r, bit s, bit p, bit b_v, logic [7:0] b, bit a, bit sl);
        rst = r; start = s; stop = p; bv = b_v; din = b; ai = a; slp = sl;
    endtask

    logic [15:0] wr_log[$];

    task automatic cyc(bit s, bit b_v, logic [7:0] b);
        drive(1'b0, s, 1'b0, b_v, b, 1'b1, 1'b1);
        @(posedge clk); #1;
        if (we) wr_log.push_back({wid, wval});
    endtask

    initial begin
        drive(1'b1, 0, 0, 0, 8'h00, 1, 1);

        // name, rst, start, stop, bv, byte, ai, sleep | we, id, val, ptr, err, check id/val
        vecs.push_back(v("reset",        1,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h00,0,1));
        vecs.push_back(v("start",        0,1,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h00,0,0));
        vecs.push_back(v("ptr06",        0,0,0,1,8'h06,1,1, 0,8'h00,8'h00,8'h06,0,0));
        vecs.push_back(v("d11",          0,0,0,1,8'h11,1,1, 0,8'h00,8'h00,8'h07,0,0));
        vecs.push_back(v("d22_wr06",     0,0,0,1,8'h22,1,1, 1,8'h06,8'h11,8'h08,0,1));
        vecs.push_back(v("wr07",         0,0,0,0,8'h00,1,1, 1,8'h07,8'h22,8'h08,0,1));
        vecs.push_back(v("one_cycle",    0,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h08,0,0));
        vecs.push_back(v("start2",       0,1,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h08,0,0));
        vecs.push_back(v("ptr45",        0,0,0,1,8'h45,1,1, 0,8'h00,8'h00,8'h45,0,0));
        vecs.push_back(v("low_wrap",     0,0,0,1,8'hA1,1,1, 0,8'h00,8'h00,8'h00,0,0));
        vecs.push_back(v("wr45",         0,0,0,1,8'hA2,1,1, 1,8'h45,8'hA1,8'h01,0,1));
        vecs.push_back(v("wr00",         0,0,0,0,8'h00,1,1, 1,8'h00,8'hA2,8'h01,0,1));
        vecs.push_back(v("start3",       0,1,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h01,0,0));
        vecs.push_back(v("ptrFD",        0,0,0,1,8'hFD,1,1, 0,8'h00,8'h00,8'hFD,0,0));
        vecs.push_back(v("FD_skip",      0,0,0,1,8'hB1,1,1, 0,8'h00,8'h00,8'hFA,0,0));
        vecs.push_back(v("wrFD",         0,0,0,1,8'hB2,1,1, 1,8'hFD,8'hB1,8'hFB,0,1));
        vecs.push_back(v("wrFA",         0,0,0,0,8'h00,1,1, 1,8'hFA,8'hB2,8'hFB,0,1));
        vecs.push_back(v("start4",       0,1,0,0,8'h00,1,1, 0,8'h00,8'h00,8'hFB,0,0));
        vecs.push_back(v("ptrFF",        0,0,0,1,8'hFF,1,1, 0,8'h00,8'h00,8'hFF,0,0));
        vecs.push_back(v("FF_wrap",      0,0,0,1,8'hC1,1,1, 0,8'h00,8'h00,8'h00,0,0));
        vecs.push_back(v("stop_byte",    0,0,1,1,8'hC2,1,1, 1,8'hFF,8'hC1,8'h01,0,1));
        vecs.push_back(v("stop_wr",      0,0,0,0,8'h00,1,1, 1,8'h00,8'hC2,8'h01,0,1));
        vecs.push_back(v("idle_ign",     0,0,0,1,8'h77,1,1, 0,8'h00,8'h00,8'h01,0,0));
        vecs.push_back(v("idle_nowr",    0,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h01,0,0));
        vecs.push_back(v("start5",       0,1,0,0,8'h00,0,1, 0,8'h00,8'h00,8'h01,0,0));
        vecs.push_back(v("ptr10",        0,0,0,1,8'h10,0,1, 0,8'h00,8'h00,8'h10,0,0));
        vecs.push_back(v("ai0_AA",       0,0,0,1,8'hAA,0,1, 0,8'h00,8'h00,8'h10,0,0));
        vecs.push_back(v("ai0_wrAA",     0,0,0,1,8'hBB,0,1, 1,8'h10,8'hAA,8'h10,0,1));
        vecs.push_back(v("ai0_wrBB",     0,0,0,1,8'hCC,0,1, 1,8'h10,8'hBB,8'h10,0,1));
        vecs.push_back(v("ai0_wrCC",     0,0,0,0,8'h00,0,1, 1,8'h10,8'hCC,8'h10,0,1));
        vecs.push_back(v("ai0_end",      0,0,0,0,8'h00,0,1, 0,8'h00,8'h00,8'h10,0,0));
        vecs.push_back(v("start_byte",   0,1,0,1,8'h99,1,1, 0,8'h00,8'h00,8'h10,0,0));
        vecs.push_back(v("sb_nowr",      0,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h10,0,0));
        vecs.push_back(v("sb_ptr20",     0,0,0,1,8'h20,1,1, 0,8'h00,8'h00,8'h20,0,0));
        vecs.push_back(v("sb_nowr2",     0,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h20,0,0));
        vecs.push_back(v("sb_d55",       0,0,0,1,8'h55,1,1, 0,8'h00,8'h00,8'h21,0,0));
        vecs.push_back(v("sb_wr20",      0,0,0,0,8'h00,1,1, 1,8'h20,8'h55,8'h21,0,1));
        vecs.push_back(v("start_stop",   0,1,1,0,8'h00,1,1, 0,8'h00,8'h00,8'h21,0,0));
        vecs.push_back(v("ss_ptr30",     0,0,0,1,8'h30,1,1, 0,8'h00,8'h00,8'h30,0,0));
        vecs.push_back(v("pre_rst_d66",  0,0,0,1,8'h66,1,1, 0,8'h00,8'h00,8'h31,0,0));
        vecs.push_back(v("rst_abort",    1,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h00,0,1));
        vecs.push_back(v("rst_nowr",     0,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h00,0,0));
        vecs.push_back(v("rst_idle",     0,0,0,1,8'h12,1,1, 0,8'h00,8'h00,8'h00,0,0));
        vecs.push_back(v("rst_idle2",    0,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h00,0,0));
        vecs.push_back(v("rst2",         1,0,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h00,0,1));
        vecs.push_back(v("start_at_rel", 0,1,0,0,8'h00,1,1, 0,8'h00,8'h00,8'h00,0,0));
        vecs.push_back(v("rel_ptr40",    0,0,0,1,8'h40,1,1, 0,8'h00,8'h00,8'h40,0,0));
        vecs.push_back(v("rel_d5A",      0,0,0,1,8'h5A,1,1, 0,8'h00,8'h00,8'h41,0,0));
        vecs.push_back(v("rel_wr40",     0,0,0,0,8'h00,1,1, 1,8'h40,8'h5A,8'h41,0,1));
        vecs.push_back(v("p_start",      0,1,0,0,8'h00,0,1, 0,8'h00,8'h00,8'h41,0,0));
        vecs.push_back(v("p_ptr50",      0,0,0,1,8'h50,0,1, 0,8'h00,8'h00,8'h50,0,0));
        vecs.push_back(v("p_d01",        0,0,0,1,8'h01,0,1, 0,8'h00,8'h00,8'h50,PROT,0));
        vecs.push_back(v("p_wr50",       0,0,0,0,8'h00,0,1, !PROT,8'h50,8'h01,8'h50,PROT,!PROT));
        vecs.push_back(v("p_errclr",     0,1,0,0,8'h00,0,1, 0,8'h00,8'h00,8'h50,0,0));
        vecs.push_back(v("p_ptrFE",      0,0,0,1,8'hFE,0,0, 0,8'h00,8'h00,8'hFE,0,0));
        vecs.push_back(v("p_d02_awake",  0,0,0,1,8'h02,0,0, 0,8'h00,8'h00,8'hFE,PROT,0));
        vecs.push_back(v("p_wrFE_awake", 0,0,0,0,8'h00,0,0, !PROT,8'hFE,8'h02,8'hFE,PROT,!PROT));
        vecs.push_back(v("p_d03_sleep",  0,0,0,1,8'h03,0,1, 0,8'h00,8'h00,8'hFE,PROT,0));
        vecs.push_back(v("p_wrFE_sleep", 0,0,0,0,8'h00,0,1, 1,8'hFE,8'h03,8'hFE,PROT,1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].bv, vecs[i].b, vecs[i].ai, vecs[i].slp);
            @(posedge clk); #1;
            check({vecs[i].name, "_we"},  {31'd0, we},   {31'd0, vecs[i].ewe});
            check({vecs[i].name, "_ptr"}, {24'd0, ptr},  {24'd0, vecs[i].eptr});
            check({vecs[i].name, "_err"}, {31'd0, err},  {31'd0, vecs[i].eerr});
            if (vecs[i].iv) begin
                check({vecs[i].name, "_id"},  {24'd0, wid},  {24'd0, vecs[i].eid});
                check({vecs[i].name, "_val"}, {24'd0, wval}, {24'd0, vecs[i].evl});
            end
        end

        // Back-to-back burst across the low-bank wrap: four writes, each a one-cycle strobe.
        wr_log.delete();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h43);
        cyc(1'b0, 1'b1, 8'hD0);
        cyc(1'b0, 1'b1, 8'hD1);
        cyc(1'b0, 1'b1, 8'hD2);
        cyc(1'b0, 1'b1, 8'hD3);
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 8'h00);
        check("burst_count", wr_log.size(), 32'd4);
        if (wr_log.size() == 4) begin
            check("burst_w0", {16'd0, wr_log[0]}, 32'h000043D0);
            check("burst_w1", {16'd0, wr_log[1]}, 32'h000044D1);
            check("burst_w2", {16'd0, wr_log[2]}, 32'h000045D2);
            check("burst_w3", {16'd0, wr_log[3]}, 32'h000000D3);
        end
        check("burst_ptr", {24'd0, ptr}, 32'h00000001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/i2c_write_sequencer.md
I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 SHALL have parameter LOW_MAX_REG, default 8'h45, which is the last register of the low bank.
REQ-002 SHALL have parameter HIGH_MIN_REG, default 8'hFA, which is the first register of the high bank.
REQ-003 clk_i  input  1  single clock; all logic on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  one-cycle pulse on an I2C START or repeated START addressed to this device in write mode.
REQ-006 stop_i  input  1  one-cycle pulse on an I2C STOP.
REQ-007 byte_valid_i  input  1  one-cycle strobe; byte_i holds a received, ACKed data byte.
REQ-008 byte_i  input  8  received data byte, MSB = first bit on the bus.
REQ-009 auto_increment_i  input  1  MODE1.AI bit taken from the register store.
REQ-010 sleep_i  input  1  MODE1.SLEEP bit taken from the register store.
REQ-011 write_register_id_o  output  8  target register address for the register store.
REQ-012 write_register_value_o  output  8  data byte for the register store.
REQ-013 write_enable_o  output  1  one-cycle write strobe to the register store.
REQ-014 pointer_o  output  8  current control-register pointer, also used by the read path.
REQ-015 error_o  output  1  sticky flag: a write was dropped; cleared on the next start_i.

Function
REQ-016 SHALL implement FSM states IDLE, PTR and DATA.
REQ-017 IDLE: start_i -> PTR; byte_valid_i is ignored.
REQ-018 PTR: byte_valid_i -> pointer_o <= byte_i, no write issued, next state DATA.
REQ-019 DATA: byte_valid_i -> issue a write of byte_i to address pointer_o, then advance the pointer per REQ-022.
REQ-020 A write SHALL assert write_enable_o for exactly one cycle, on the edge after the byte_valid_i sample; id/value SHALL be stable while the strobe is high.
REQ-021 stop_i from any state -> IDLE; pointer_o is retained.
REQ-022 Pointer advance with auto_increment_i=1: LOW_MAX_REG -> 8'h00; 8'hFD -> HIGH_MIN_REG; 8'hFF -> 8'h00; otherwise +1.
REQ-023 Pointer advance with auto_increment_i=0: pointer_o is unchanged; successive bytes overwrite the same register.
REQ-024 The pointer SHALL advance even when the write is dropped.
REQ-025 start_i in PTR or DATA (repeated START) -> PTR, and error_o is cleared.
REQ-026 start_i and byte_valid_i in the same cycle: start_i wins and the byte is discarded.
REQ-027 stop_i and byte_valid_i in the same cycle in DATA: the byte is written first, then the FSM goes to IDLE.
REQ-028 start_i and stop_i in the same cycle: start_i wins.
REQ-029 Back-to-back byte_valid_i on consecutive cycles SHALL each produce a write, with no loss.

Reset
REQ-030 rst_i SHALL force state IDLE, pointer_o=8'h00, write_register_id_o=8'h00, write_register_value_o=8'h00, write_enable_o=0 and error_o=0.
REQ-031 rst_i asserted mid-transaction SHALL abort it; a write pending from the previous cycle's byte SHALL NOT be issued.
REQ-032 After rst_i, the block SHALL accept start_i on the first cycle rst_i is low.

Configuration
REQ-033 Macro WRITE_SEQ_PROTECT_EN, when defined: writes to LOW_MAX_REG+1..HIGH_MIN_REG-1 (reserved) are dropped, with no strobe and error_o set.
REQ-034 WRITE_SEQ_PROTECT_EN, when defined: writes to 8'hFE (PRE_SCALE) while sleep_i=0 are dropped and error_o is set.
REQ-035 Without WRITE_SEQ_PROTECT_EN: all DATA bytes are written, error_o is tied 0, and sleep_i is unused.

Verification
REQ-036 Reset, start, byte 8'h06, bytes 8'h11, 8'h22 with AI=1 -> writes (06,11) then (07,22); pointer_o=8'h08.
REQ-037 AI=1, pointer 8'h45, then two bytes -> writes to 8'h45 then 8'h00; pointer 8'hFD, then two bytes -> writes to 8'hFD then 8'hFA.
REQ-038 AI=0, pointer 8'h10, bytes 8'hAA, 8'hBB, 8'hCC -> three writes, all to 8'h10; pointer_o stays 8'h10.
REQ-039 start_i and byte_valid_i coincident in DATA -> no strobe, state PTR; the next byte loads the pointer.
REQ-040 With WRITE_SEQ_PROTECT_EN: write to 8'h50 -> no strobe, error_o=1; with sleep_i=0, write to 8'hFE -> no strobe; with sleep_i=1, write to 8'hFE -> strobe.
REQ-041 rst_i pulsed the cycle after a DATA byte -> write_enable_o stays 0, pointer_o=8'h00, state IDLE.
